// File: rtl/program_loader.sv
// Boot loader: accepts a length byte, L data bytes and an XOR checksum, writes the data to program memory and releases the CPU reset only after the checksum matches.
// Latency: each data byte appears on the memory write port one cycle after its transfer. Backpressure: byteReady is decoded from the registered state, not from byteValid.
module program_loader #(
    parameter int ADDWIDTH  = 7,
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] byteIn,
    input  logic                 byteValid,
    output logic                 byteReady,
    output logic                 pmWrEn,
    output logic [ADDWIDTH-1:0]  pmAddr,
    output logic [DATAWIDTH-1:0] pmData,
    output logic                 cpuRst,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, RUN, ERR} state_t;

    localparam logic [DATAWIDTH:0] MAXLEN = (DATAWIDTH+1)'(2**ADDWIDTH);

    state_t               state;
    state_t               nextState;
    logic [ADDWIDTH-1:0]  addrCnt;
    logic [DATAWIDTH-1:0] remaining;
    logic [DATAWIDTH-1:0] checksum;
    logic                 xfer;
    logic                 lenBad;
    logic                 lastData;

    assign byteReady = (state == LEN) || (state == DATA) || (state == CHK);
    assign busy      = byteReady;
    assign done      = (state == RUN);
    assign error     = (state == ERR);

    assign xfer     = byteValid && byteReady;
    assign lenBad   = (byteIn == '0) || ({1'b0, byteIn} > MAXLEN);
    assign lastData = (remaining == DATAWIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, RUN, ERR: if (start) nextState = LEN;
            LEN:            if (xfer) nextState = lenBad ? ERR : DATA;
            DATA:           if (xfer && lastData) nextState = CHK;
            CHK:            if (xfer) nextState = (byteIn == checksum) ? RUN : ERR;
            default:        nextState = IDLE;
        endcase
    end

    // cpuRst follows nextState so it drops with the first RUN cycle and
    // rises on the same edge a reload leaves RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrCnt   <= '0;
            remaining <= '0;
            checksum  <= '0;
            pmWrEn    <= 1'b0;
            pmAddr    <= '0;
            pmData    <= '0;
            cpuRst    <= 1'b1;
        end else begin
            pmWrEn <= 1'b0;
            cpuRst <= (nextState != RUN);
            case (state)
                IDLE, RUN, ERR: begin
                    if (start) begin
                        checksum <= '0;
                        addrCnt  <= '0;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        checksum  <= checksum ^ byteIn;
                        remaining <= byteIn;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        pmWrEn    <= 1'b1;
                        pmAddr    <= addrCnt;
                        pmData    <= byteIn;
                        checksum  <= checksum ^ byteIn;
                        remaining <= remaining - 1'b1;
                        // hold the counter on the last byte so a full-size load never wraps
                        if (!lastData) addrCnt <= addrCnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table-driven load streams plus hand-written reload/reset sequences; memory writes checked against a scoreboard queue.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] byteIn;
    logic       byteValid;
    logic       byteReady;
    logic       pmWrEn;
    logic [6:0] pmAddr;
    logic [7:0] pmData;
    logic       cpuRst;
    logic       busy;
    logic       done;
    logic       error;

    program_loader #(.ADDWIDTH(7), .DATAWIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .byteIn(byteIn), .byteValid(byteValid),
        .byteReady(byteReady), .pmWrEn(pmWrEn), .pmAddr(pmAddr), .pmData(pmData),
        .cpuRst(cpuRst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [31:0] t;
    } wr_t;

    typedef struct {
        logic [0:5][7:0] bytes;
        int              n;
        bit              gaps;
        bit              expDone;
        int              expWrites;
    } vec_t;

    wr_t  expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   writeCount = 0;
    int   tick = 0;
    logic [6:0] lastAddr = '0;

    always @(posedge clk) tick <= tick + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // write monitor: every pmWrEn must match the oldest expected write, in the expected cycle
    always @(negedge clk) begin
        if (pmWrEn !== 1'b0) begin
            writeCount++;
            lastAddr = pmAddr;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", pmAddr, pmData);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                chk("write_addr", 32'(pmAddr), 32'(e.addr));
                chk("write_data", 32'(pmData), 32'(e.data));
                chk("write_cycle", 32'(tick), e.t);
            end
        end
    end

    task automatic sendByte(input logic [7:0] b, input bit isData, input logic [6:0] a, input bit gaps);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                chk("byte_accept_timeout", 32'(byteReady), 32'd1);
                break;
            end
            if (gaps && $urandom_range(0, 1) == 0) begin
                byteValid = 1'b0;
                byteIn    = 8'($urandom);
            end else begin
                byteValid = 1'b1;
                byteIn    = b;
                if (byteReady === 1'b1) begin
                    if (isData) expQ.push_back('{addr: a, data: b, t: 32'(tick + 1)});
                    break;
                end
            end
        end
    endtask

    task automatic startLoad();
        writeCount = 0;
        @(negedge clk);
        byteValid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("cpuRst_during_load", 32'(cpuRst), 32'd1);
    endtask

    task automatic finishLoad(input bit expDone, input int expWrites);
        @(negedge clk);
        byteValid = 1'b0;
        @(negedge clk);
        chk("done", 32'(done), 32'(expDone));
        chk("error", 32'(error), 32'(!expDone));
        chk("cpuRst", 32'(cpuRst), 32'(!expDone));
        chk("busy_end", 32'(busy), 32'd0);
        chk("write_count", 32'(writeCount), 32'(expWrites));
        chk("pending_writes", 32'(expQ.size()), 32'd0);
    endtask

    task automatic checkResetOutputs();
        chk("rst_byteReady", 32'(byteReady), 32'd0);
        chk("rst_pmWrEn", 32'(pmWrEn), 32'd0);
        chk("rst_pmAddr", 32'(pmAddr), 32'd0);
        chk("rst_pmData", 32'(pmData), 32'd0);
        chk("rst_cpuRst", 32'(cpuRst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[5];
        logic [7:0] x;
        int len;

        vecs[0] = '{bytes: {8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'h00}, n: 5, gaps: 1'b0, expDone: 1'b1, expWrites: 3};
        vecs[1] = '{bytes: {8'h02, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00}, n: 4, gaps: 1'b0, expDone: 1'b0, expWrites: 2};
        vecs[2] = '{bytes: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 1, gaps: 1'b0, expDone: 1'b0, expWrites: 0};
        vecs[3] = '{bytes: {8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 1, gaps: 1'b0, expDone: 1'b0, expWrites: 0};
        vecs[4] = '{bytes: {8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h26}, n: 6, gaps: 1'b1, expDone: 1'b1, expWrites: 4};

        rst = 1'b1;
        start = 1'b0;
        byteIn = 8'h00;
        byteValid = 1'b0;
        #1;
        checkResetOutputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_reset_busy", 32'(busy), 32'd0);
        chk("idle_after_reset_cpuRst", 32'(cpuRst), 32'd1);

        for (int v = 0; v < 5; v++) begin
            startLoad();
            len = int'(vecs[v].bytes[0]);
            for (int i = 0; i < vecs[v].n; i++) begin
                sendByte(vecs[v].bytes[i], (i >= 1) && (i <= len), 7'(i - 1), vecs[v].gaps);
            end
            finishLoad(vecs[v].expDone, vecs[v].expWrites);
        end

        // full-size load: 128 bytes, last write at the top address
        startLoad();
        x = 8'h80;
        sendByte(8'h80, 1'b0, 7'h00, 1'b0);
        for (int i = 0; i < 128; i++) begin
            x = x ^ 8'(i * 3 + 1);
            sendByte(8'(i * 3 + 1), 1'b1, 7'(i), 1'b0);
        end
        sendByte(x, 1'b0, 7'h00, 1'b0);
        finishLoad(1'b1, 128);
        chk("last_write_addr", 32'(lastAddr), 32'h7F);

        // reload from RUN must reassert cpuRst on the next cycle
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reload_cpuRst", 32'(cpuRst), 32'd1);
        chk("reload_busy", 32'(busy), 32'd1);
        writeCount = 0;
        sendByte(8'h01, 1'b0, 7'h00, 1'b0);
        sendByte(8'h5A, 1'b1, 7'h00, 1'b0);
        sendByte(8'h5B, 1'b0, 7'h00, 1'b0);
        finishLoad(1'b1, 1);

        // reset in the middle of a 5-byte load
        startLoad();
        sendByte(8'h05, 1'b0, 7'h00, 1'b0);
        sendByte(8'hC1, 1'b1, 7'h00, 1'b0);
        sendByte(8'hC2, 1'b1, 7'h01, 1'b0);
        @(negedge clk);
        byteValid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs();
        byteValid = 1'b1;
        byteIn = 8'h77;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_abort_busy", 32'(busy), 32'd0);
        chk("post_abort_byteReady", 32'(byteReady), 32'd0);
        chk("post_abort_cpuRst", 32'(cpuRst), 32'd1);
        chk("post_abort_done", 32'(done), 32'd0);
        chk("post_abort_error", 32'(error), 32'd0);
        chk("post_abort_writes", 32'(writeCount), 32'd2);
        chk("post_abort_pending", 32'(expQ.size()), 32'd0);
        byteValid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
